// File: rtl/uart_frame_arbiter.sv
// -----------------------------------------------------------------------------
// uart_frame_arbiter
//
// Round-robin arbiter sharing one uart_tx byte transmitter between NUM_REQ
// frame sources. A grant covers a whole frame: the arbiter walks byte_index
// from 0 to FRAME_LENGTH-1, pulses tx_transmit once per byte, waits for the
// transmitter's busy flag to rise and fall, and after the last byte inserts
// an idle gap of GAP_CYCLES clocks before arbitrating again.
//
// Ports:
//   CLK          in   sole clock, rising edge
//   reset        in   synchronous, active-high
//   req          in   per-requester frame request level (sampled in IDLE only)
//   frame_data   in   byte from requester k on [8k+7:8k], selected by byte_index
//   grant        out  one-hot owner of the transmitter, 0 when no frame
//   byte_index   out  index of the byte requested from the owner
//   frame_done   out  one-cycle pulse on the owner's bit after its last byte
//   busy         out  high in every state except IDLE
//   tx_transmit  out  one-cycle start pulse to uart_tx
//   tx_data      out  frame_data of the granted requester, 0 when none
//   tx_active    in   busy flag from uart_tx
// -----------------------------------------------------------------------------
module uart_frame_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int FRAME_LENGTH = 20,
  parameter int GAP_CYCLES   = 1024
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] frame_data,
  output logic [NUM_REQ-1:0]   grant,
  output logic [7:0]           byte_index,
  output logic [NUM_REQ-1:0]   frame_done,
  output logic                 busy,
  output logic                 tx_transmit,
  output logic [7:0]           tx_data,
  input  logic                 tx_active
);

  localparam int IDX_W = $clog2(NUM_REQ);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_SEND    = 3'd2;
  localparam logic [2:0] S_WAIT_HI = 3'd3;
  localparam logic [2:0] S_WAIT_LO = 3'd4;
  localparam logic [2:0] S_GAP     = 3'd5;

  localparam logic [7:0]         LAST_BYTE  = 8'(FRAME_LENGTH - 1);
  localparam logic [15:0]        GAP_LOAD   = 16'(GAP_CYCLES);
  localparam logic [IDX_W-1:0]   LAST_RESET = IDX_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0   = NUM_REQ'(1);
  // With no gap configured the last byte returns straight to IDLE.
  localparam logic [2:0]         AFTER_FRAME = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;

  logic [2:0]         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [7:0]         byte_index_q, byte_index_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [15:0]        gap_q, gap_d;
  logic [NUM_REQ-1:0] frame_done_q, frame_done_d;

  // Round-robin pick: scan offsets NUM_REQ down to 1 from last_q so the
  // smallest offset (the first requester after the previous owner) wins.
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   cand;

  // NOTE: every signal assigned in a combinational block gets a default at the
  // top, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = IDX_W'((int'(last_q) + i) % NUM_REQ);
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Byte mux driven by the one-hot grant; all-zero grant yields 0.
  logic [7:0] tx_data_mux;

  always_comb begin
    tx_data_mux = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_q[k]) tx_data_mux = tx_data_mux | frame_data[8*k +: 8];
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    byte_index_d = byte_index_q;
    last_d       = last_q;
    gap_d        = gap_q;
    frame_done_d = '0;

    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          grant_d      = ONE_HOT0 << pick_idx;
          byte_index_d = '0;
          last_d       = pick_idx;
          state_d      = S_LOAD;
        end
      end
      // One settling cycle so the owner can present byte 0.
      S_LOAD:    state_d = S_SEND;
      S_SEND:    state_d = S_WAIT_HI;
      S_WAIT_HI: if (tx_active) state_d = S_WAIT_LO;
      S_WAIT_LO: begin
        if (!tx_active) begin
          if (byte_index_q < LAST_BYTE) begin
            byte_index_d = byte_index_q + 8'd1;
            state_d      = S_SEND;
          end else begin
            frame_done_d = grant_q;
            grant_d      = '0;
            gap_d        = GAP_LOAD;
            state_d      = AFTER_FRAME;
          end
        end
      end
      S_GAP: begin
        gap_d = gap_q - 16'd1;
        if (gap_q == 16'd1) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block order.
  // NOTE: the reset is synchronous, checked inside the clocked block; a reset
  // mid-frame drops the frame with no frame_done and restores the priority.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      byte_index_q <= '0;
      last_q       <= LAST_RESET;
      gap_q        <= '0;
      frame_done_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      byte_index_q <= byte_index_d;
      last_q       <= last_d;
      gap_q        <= gap_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign grant       = grant_q;
  assign byte_index  = byte_index_q;
  assign frame_done  = frame_done_q;
  assign busy        = (state_q != S_IDLE);
  assign tx_transmit = (state_q == S_SEND);
  assign tx_data     = tx_data_mux;

endmodule
